data_mem_responder: RTL and testbench

//  - Memory-side responder for the CPU's load/store port: accepts one request per handshake, waits
//    a fixed latency, then returns a response. Applies the RV32 sub-word rules for loads and stores.
//  - Sits behind the core's data-memory wrapper and replaces the zero-latency data memory, so a

---
 rtl/data_mem_if.sv | 24 ++
 rtl/data_mem_responder.sv | 141 ++++++++++++++
 tb/tb_data_mem_responder.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// Load/store port between the core's data-memory wrapper (master) and the
// memory-side responder (slave): one request channel, one response channel.
interface data_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency RV32 data memory responder, one request in flight at a time.
// Optional macro MISALIGN_TRAP_EN: misaligned half/word accesses return resp_err=1.
//
// state | meaning
// IDLE  | ready for a request; request fields are latched on acceptance
// WAIT  | latency countdown; the access happens on the edge that leaves WAIT
// RESP  | response held on the bus until resp_ready
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input logic       clk,
  input logic       rst,
  data_mem_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            accept, access;

  logic            we_q;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [2:0]      funct3_q;
  logic [31:0]     rdata_q;
  logic            err_q;

  logic [31:0]     mem [DEPTH_WORDS];
  logic [AW-1:0]   idx;
  logic [31:0]     word;
  logic            is_byte, is_half, misaligned;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [31:0]     load_val;
  logic [3:0]      be;
  logic [31:0]     wdata_rep;

  // Address bits above the memory size wrap and are never looked at.
  logic unused_addr;
  assign unused_addr = &{1'b0, bus.req_addr[31:AW+2]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    access  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          cnt_d   = 4'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign idx  = addr_q[AW+1:2];
  assign word = mem[idx];

  // Store codes other than SB/SH are words; load codes split on funct3[1:0].
  always_comb begin
    is_byte    = we_q ? (funct3_q == 3'b000) : (funct3_q[1:0] == 2'b00);
    is_half    = we_q ? (funct3_q == 3'b001) : (funct3_q[1:0] == 2'b01);
`ifdef MISALIGN_TRAP_EN
    misaligned = (is_half && addr_q[0]) ||
                 (!is_byte && !is_half && (addr_q[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif
    byte_sel   = word[{addr_q[1:0], 3'b000} +: 8];
    half_sel   = addr_q[1] ? word[31:16] : word[15:0];
    load_val   = word;
    be         = 4'b1111;
    wdata_rep  = wdata_q;
    if (is_byte) begin
      load_val  = funct3_q[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      be        = 4'b0001 << addr_q[1:0];
      wdata_rep = {4{wdata_q[7:0]}};
    end else if (is_half) begin
      load_val  = funct3_q[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      be        = addr_q[1] ? 4'b1100 : 4'b0011;
      wdata_rep = {2{wdata_q[15:0]}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 32'b0;
      funct3_q <= 3'b0;
      rdata_q  <= 32'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q     <= bus.req_we;
        addr_q   <= bus.req_addr[AW+1:0];
        wdata_q  <= bus.req_wdata;
        funct3_q <= bus.req_funct3;
      end
      if (access) begin
        rdata_q <= (we_q || misaligned) ? 32'b0 : load_val;
        err_q   <= misaligned;
      end
    end
  end

  // RAM is not reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && access && we_q && !misaligned) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, reset corner cases and
// random traffic against a byte-addressed reference memory.
module tb_data_mem_responder;
  localparam int LAT   = 4;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_if bus();

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t        vecs[$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  mb [DEPTH*4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [2:0] f3, input int hold,
                              input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.f3 = f3; v.hold = hold;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  function automatic int acc_size(input logic we, input logic [2:0] f3);
    if (we) return (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  // Reference: byte-addressed memory, wrap modulo size, natural alignment.
  task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [2:0] f3, output logic [31:0] rd, output logic er);
    int a, n, base;
    logic [31:0] v;
    n    = acc_size(we, f3);
    a    = int'(addr % 32'(DEPTH*4));
    base = a - (a % n);
`ifdef MISALIGN_TRAP_EN
    er = ((a % n) != 0);
`else
    er = 1'b0;
`endif
    rd = 32'b0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < n; i++) mb[base+i] = wdata[8*i +: 8];
      end else begin
        v = 32'b0;
        for (int i = 0; i < n; i++) v = v | (32'(mb[base+i]) << (8*i));
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        rd = v;
      end
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the response handshake edge.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [2:0] f3, input int hold, input string tag,
                     output logic [31:0] rd, output logic er);
    int t;
    logic [31:0] r0;
    logic        e0;
    bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wdata; bus.req_funct3 = f3;
    bus.req_valid = 1'b1;
    t = 0;
    while (!bus.req_ready && t < 20) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    bus.req_funct3 = 3'($urandom);
    t = 0;
    while (!bus.resp_valid && t < 40) begin @(posedge clk); #1; t++; end
    chk({tag, " latency"}, t, LAT);
    r0 = bus.resp_rdata;
    e0 = bus.resp_err;
    for (int h = 0; h < hold; h++) begin
      bus.req_valid = 1'b1;
      @(posedge clk); #1;
      chk({tag, " hold valid/ready"}, {30'b0, bus.resp_valid, bus.req_ready}, 32'h2);
      chk({tag, " hold rdata"}, bus.resp_rdata, r0);
      chk({tag, " hold err"}, 32'(bus.resp_err), 32'(e0));
    end
    bus.req_valid = 1'b0;
    rd = bus.resp_rdata;
    er = bus.resp_err;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk({tag, " back to idle"}, {30'b0, bus.req_ready, bus.resp_valid}, 32'h2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, m_rd, d, a;
    logic        er, m_er, w;
    logic [2:0]  f;

    vecs.push_back(mk(1, 32'h10,  32'hDEADBEEF, 3'b010, 0, 32'h0, 0));
    vecs.push_back(mk(0, 32'h10,  32'h0,        3'b010, 0, 32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 32'h20,  32'h0,        3'b010, 0, 32'h0, 0));
    vecs.push_back(mk(1, 32'h21,  32'h00000080, 3'b000, 0, 32'h0, 0));
    vecs.push_back(mk(1, 32'h22,  32'h00001234, 3'b001, 0, 32'h0, 0));
    vecs.push_back(mk(0, 32'h20,  32'h0,        3'b010, 0, 32'h12348000, 0));
    vecs.push_back(mk(0, 32'h21,  32'h0,        3'b000, 0, 32'hFFFFFF80, 0));
    vecs.push_back(mk(0, 32'h21,  32'h0,        3'b100, 0, 32'h00000080, 0));
    vecs.push_back(mk(0, 32'h22,  32'h0,        3'b001, 0, 32'h00001234, 0));
    vecs.push_back(mk(0, 32'h20,  32'h0,        3'b001, 0, 32'hFFFF8000, 0));
    vecs.push_back(mk(0, 32'h20,  32'h0,        3'b101, 0, 32'h00008000, 0));
    vecs.push_back(mk(0, 32'h20,  32'h0,        3'b111, 0, 32'h12348000, 0));
    vecs.push_back(mk(1, 32'h0,   32'h01020304, 3'b010, 0, 32'h0, 0));
    vecs.push_back(mk(0, 32'h400, 32'h0,        3'b010, 5, 32'h01020304, 0));
`ifdef MISALIGN_TRAP_EN
    vecs.push_back(mk(0, 32'h13,  32'h0,        3'b010, 0, 32'h0, 1));
    vecs.push_back(mk(1, 32'h11,  32'h00005555, 3'b001, 0, 32'h0, 1));
    vecs.push_back(mk(0, 32'h10,  32'h0,        3'b010, 0, 32'hDEADBEEF, 0));
`else
    vecs.push_back(mk(0, 32'h13,  32'h0,        3'b010, 0, 32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 32'h11,  32'h00005555, 3'b001, 0, 32'h0, 0));
    vecs.push_back(mk(0, 32'h10,  32'h0,        3'b010, 0, 32'hDEAD5555, 0));
`endif

    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 32'b0;
    bus.req_wdata = 32'b0; bus.req_funct3 = 3'b0; bus.resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset req_ready",  32'(bus.req_ready),  32'h1);
    chk("reset resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("reset resp_rdata", bus.resp_rdata,      32'h0);
    chk("reset resp_err",   32'(bus.resp_err),   32'h0);
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      model_access(1'b1, 32'(i*4), d, 3'b010, m_rd, m_er);
      txn(1'b1, 32'(i*4), d, 3'b010, 0, "init", rd, er);
      chk("init store rdata", rd, 32'h0);
    end

    foreach (vecs[i]) begin
      model_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, m_rd, m_er);
      txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].f3, vecs[i].hold,
          $sformatf("vec%0d", i), rd, er);
      chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].exp_err));
    end

    // Reset during the second WAIT cycle of a store: no response, no write.
    model_access(1'b0, 32'h30, 32'h0, 3'b010, m_rd, m_er);
    bus.req_we = 1'b1; bus.req_addr = 32'h30; bus.req_wdata = 32'hAAAAAAAA;
    bus.req_funct3 = 3'b010; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < LAT + 2; c++) begin
      chk("abort no response", {30'b0, bus.resp_valid, bus.req_ready}, 32'h1);
      @(posedge clk); #1;
    end
    txn(1'b0, 32'h30, 32'h0, 3'b010, 0, "abort reload", rd, er);
    chk("abort old value", rd, m_rd);

    for (int i = 0; i < 300; i++) begin
      w = 1'($urandom);
      a = 32'($urandom_range(0, 32'h7FF));
      d = $urandom;
      f = 3'($urandom);
      model_access(w, a, d, f, m_rd, m_er);
      txn(w, a, d, f, int'($urandom_range(0, 2)), "rand", rd, er);
      chk($sformatf("rand%0d rdata a=%08h f3=%0d we=%0d", i, a, f, w), rd, m_rd);
      chk($sformatf("rand%0d err", i), 32'(er), 32'(m_er));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
